// File: rtl/fp_addsub_pkg.sv
// fp_addsub shared constants.
// Rounding-mode codes and status bit positions.
package fp_addsub_pkg;

  localparam logic [2:0] RND_NE = 3'd0;
  localparam logic [2:0] RND_TZ = 3'd1;
  localparam logic [2:0] RND_UP = 3'd2;
  localparam logic [2:0] RND_DN = 3'd3;
  localparam logic [2:0] RND_NA = 3'd4;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_INV     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

endpackage

// File: rtl/fp_addsub_lzc.sv
// Leading-zero counter for the fp_addsub normaliser.
// An all-zero input reports P_W.
module fp_addsub_lzc
  import fp_addsub_pkg::*;
#(
  parameter int P_W  = 15,
  parameter int P_CW = $clog2(P_W + 1)
) (
  input  logic [P_W-1:0]  val_i,
  output logic [P_CW-1:0] cnt_o
);

  logic hit;

  always_comb begin
    cnt_o = P_CW'(P_W);
    hit   = 1'b0;
    for (int i = P_W - 1; i >= 0; i--) begin
      if (!hit && val_i[i]) begin
        cnt_o = P_CW'(P_W - 1 - i);
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub.sv
// Floating-point add/subtract with subnormals, five rounding modes
// and an 8-bit exception status; one registered stage.
module fp_addsub
  import fp_addsub_pkg::*;
#(
  parameter int P_EXP  = 5,
  parameter int P_FRAC = 10,
  parameter int P_BIAS = 15,
  parameter int P_WORD = 1 + P_EXP + P_FRAC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [P_WORD-1:0] a,
  input  logic [P_WORD-1:0] b,
  input  logic              op,
  input  logic [2:0]        rnd,
  output logic [P_WORD-1:0] z,
  output logic [7:0]        status
);

  localparam int EW    = P_EXP + 2;
  localparam int MW    = P_FRAC + 1;
  localparam int XW    = P_FRAC + 4;
  localparam int SW    = P_FRAC + 5;
  localparam int CW    = $clog2(SW + 1);
  localparam int SHMAX = P_FRAC + 3;
  localparam int EMIN  = 1 - P_BIAS;

  localparam logic [P_EXP-1:0]  EONES = {P_EXP{1'b1}};
  localparam logic [P_EXP-1:0]  EMAXF = {{(P_EXP-1){1'b1}}, 1'b0};
  localparam logic [P_FRAC-1:0] FZERO = {P_FRAC{1'b0}};
  localparam logic [P_FRAC-1:0] FONES = {P_FRAC{1'b1}};
  localparam logic [P_WORD-1:0] QNAN  =
    {1'b0, EONES, 1'b1, {(P_FRAC-1){1'b0}}};

  logic              sa, sb;
  logic [P_EXP-1:0]  ea, eb;
  logic [P_FRAC-1:0] fa, fb;
  logic              nan_a, nan_b, inf_a, inf_b;
  logic              zro_a, zro_b, zs;

  assign {sa, ea, fa} = a;
  assign {eb, fb}     = b[P_WORD-2:0];
  assign sb           = b[P_WORD-1] ^ op;

  assign nan_a = (&ea) & (|fa);
  assign nan_b = (&eb) & (|fb);
  assign inf_a = (&ea) & ~(|fa);
  assign inf_b = (&eb) & ~(|fb);
  assign zro_a = ~(|a[P_WORD-2:0]);
  assign zro_b = ~(|b[P_WORD-2:0]);

  logic              a_big, sl, ss;
  logic [P_EXP-1:0]  el, es;
  logic [P_FRAC-1:0] fl, fs;
  logic [EW-1:0]     xl, xs, dexp, sh;
  logic [XW-1:0]     ext_l, ext_s, mask, al;
  logic [SW-1:0]     sum;
  logic [CW-1:0]     lz;

  // magnitude order of {exp,frac} equals numeric order
  assign a_big = a[P_WORD-2:0] >= b[P_WORD-2:0];
  assign {sl, el, fl} = a_big ? {sa, ea, fa} : {sb, eb, fb};
  assign {ss, es, fs} = a_big ? {sb, eb, fb} : {sa, ea, fa};

  assign xl    = (el == '0) ? EW'(1) : EW'(el);
  assign xs    = (es == '0) ? EW'(1) : EW'(es);
  assign dexp  = xl - xs;
  assign sh    = (dexp > EW'(SHMAX)) ? EW'(SHMAX) : dexp;
  assign ext_l = {|el, fl, 3'b000};
  assign ext_s = {|es, fs, 3'b000};
  assign mask  = (XW'(1) << sh) - XW'(1);
  assign al    = (ext_s >> sh) | XW'(|(ext_s & mask));

  assign sum = (sl ^ ss) ? {1'b0, ext_l} - {1'b0, al}
                         : {1'b0, ext_l} + {1'b0, al};

  fp_addsub_lzc #(
    .P_W  (SW),
    .P_CW (CW)
  ) u_lzc (
    .val_i (sum),
    .cnt_o (lz)
  );

  logic [EW-1:0] lsh, lim, shl, en, ef;
  logic [SW-2:0] norm;
  logic [MW-1:0] m;
  logic [MW:0]   mr;
  logic [P_FRAC-1:0] fo;
  logic g, st, inc, ovf, to_inf;

  assign lsh = EW'(lz) - EW'(1);
  assign lim = xl - EW'(1);
  assign shl = (lsh < lim) ? lsh : lim;

  // left shift stops at exponent 1, leaving a subnormal
  always_comb begin
    if (sum[SW-1]) begin
      norm = {sum[SW-1:2], sum[1] | sum[0]};
      en   = xl + EW'(1);
    end else begin
      norm = sum[SW-2:0] << shl;
      en   = xl - shl;
    end
  end

  assign m  = norm[SW-2:3];
  assign g  = norm[2];
  assign st = norm[1] | norm[0];

  always_comb begin
    unique case (1'b1)
      (rnd == RND_NE): inc = g & (st | m[0]);
      (rnd == RND_TZ): inc = 1'b0;
      (rnd == RND_UP): inc = ~sl & (g | st);
      (rnd == RND_DN): inc = sl & (g | st);
      (rnd == RND_NA): inc = g;
      default:         inc = g & (st | m[0]);
    endcase
  end

  assign mr = {1'b0, m} + {{MW{1'b0}}, inc};

  always_comb begin
    if (mr[MW]) begin
      ef = en + EW'(1);
      fo = mr[MW-1:1];
    end else begin
      ef = mr[MW-1] ? en : '0;
      fo = mr[P_FRAC-1:0];
    end
  end

  assign ovf    = ef >= EW'(EONES);
  assign to_inf = ~((rnd == RND_TZ) |
                    ((rnd == RND_UP) & sl) |
                    ((rnd == RND_DN) & ~sl));
  assign zs     = (zro_a & zro_b & ~(sa ^ sb)) ? sa
                                               : (rnd == RND_DN);

  logic [P_WORD-1:0] z_d, z_q;
  logic [7:0]        st_d, st_q;

  always_comb begin
    z_d  = '0;
    st_d = '0;
    if (nan_a | nan_b | (inf_a & inf_b & (sa ^ sb))) begin
      z_d          = QNAN;
      st_d[ST_INV] = 1'b1;
    end else if (inf_a | inf_b) begin
      z_d          = {inf_a ? sa : sb, EONES, FZERO};
      st_d[ST_INF] = 1'b1;
    end else if (sum == '0) begin
      z_d           = {zs, {(P_WORD-1){1'b0}}};
      st_d[ST_ZERO] = 1'b1;
    end else if (ovf) begin
      z_d = to_inf ? {sl, EONES, FZERO} : {sl, EMAXF, FONES};
      st_d[ST_INF]     = to_inf;
      st_d[ST_HUGE]    = 1'b1;
      st_d[ST_INEXACT] = 1'b1;
    end else begin
      z_d              = {sl, ef[P_EXP-1:0], fo};
      st_d[ST_TINY]    = (int'(ef) - P_BIAS) < EMIN;
      st_d[ST_INEXACT] = g | st;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q  <= '0;
      st_q <= '0;
    end else begin
      z_q  <= z_d;
      st_q <= st_d;
    end
  end

  assign z      = z_q;
  assign status = st_q;

endmodule

// File: tb/tb_fp_addsub.sv
// Bench for fp_addsub (binary16): directed cases plus a random
// sweep against an exact integer-arithmetic reference.
module tb_fp_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b, z;
  logic        op;
  logic [2:0]  rnd;
  logic [7:0]  status;
  int          errs = 0;
  int          checks = 0;

  fp_addsub dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .op     (op),
    .rnd    (rnd),
    .z      (z),
    .status (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic apply(input logic [15:0] ai, input logic [15:0] bi,
                       input logic opi, input logic [2:0] rm);
    a = ai;
    b = bi;
    op = opi;
    rnd = rm;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [15:0] ai,
                     input logic [15:0] bi, input logic opi,
                     input logic [2:0] rm, input logic [15:0] zw,
                     input logic [7:0] sw);
    apply(ai, bi, opi, rm);
    check({tag, " z"}, 32'(z), 32'(zw));
    check({tag, " status"}, 32'(status), 32'(sw));
  endtask

  // value in units of 2^-24, the smallest subnormal
  function automatic longint unsigned units(input logic [15:0] x);
    longint unsigned m;
    int e;
    e = (x[14:10] == 5'd0) ? 1 : int'(x[14:10]);
    m = longint'(x[9:0]) + ((x[14:10] != 5'd0) ? 64'd1024 : 64'd0);
    return m << (e - 1);
  endfunction

  function automatic int msb(input longint unsigned x);
    int r = -1;
    for (int i = 0; i < 64; i++) if (x[i]) r = i;
    return r;
  endfunction

  task automatic model(input logic [15:0] ai, input logic [15:0] bi,
                       input logic opi, input logic [2:0] rm,
                       output logic [15:0] zo, output logic [7:0] so);
    logic sa, sb, s, up, to_inf;
    bit na, nb, ia, ib;
    longint sv, va, vb;
    longint unsigned x, q, qq, r, v, fr;
    int lg, e;
    sa = ai[15];
    sb = bi[15] ^ opi;
    na = (ai[14:10] == 5'h1F) && (ai[9:0] != 0);
    nb = (bi[14:10] == 5'h1F) && (bi[9:0] != 0);
    ia = (ai[14:10] == 5'h1F) && (ai[9:0] == 0);
    ib = (bi[14:10] == 5'h1F) && (bi[9:0] == 0);
    zo = 16'h0000;
    so = 8'h00;
    if (na || nb || (ia && ib && sa != sb)) begin
      zo = 16'h7E00;
      so[2] = 1'b1;
    end else if (ia || ib) begin
      zo = {ia ? sa : sb, 15'h7C00};
      so[1] = 1'b1;
    end else begin
      va = longint'(units(ai));
      vb = longint'(units(bi));
      sv = (sa ? -va : va) + (sb ? -vb : vb);
      if (sv == 0) begin
        s = (ai[14:0] == 0 && bi[14:0] == 0 && sa == sb) ? sa : (rm == 3'd3);
        zo = {s, 15'h0000};
        so[0] = 1'b1;
      end else begin
        s = sv < 0;
        x = (sv < 0) ? -sv : sv;
        lg = msb(x);
        q = (lg <= 10) ? 64'd1 : (64'd1 << (lg - 10));
        qq = x / q;
        r = x % q;
        case (rm)
          3'd1: up = 1'b0;
          3'd2: up = (r != 0) && !s;
          3'd3: up = (r != 0) && s;
          3'd4: up = (r != 0) && (2 * r >= q);
          default: up = (2 * r > q) || ((2 * r == q) && qq[0]);
        endcase
        v = (qq + 64'(up)) * q;
        so[5] = r != 0;
        if (v >= (64'd1 << 40)) begin
          to_inf = !(rm == 3'd1 || (rm == 3'd2 && s) || (rm == 3'd3 && !s));
          zo = to_inf ? {s, 15'h7C00} : {s, 15'h7BFF};
          so[1] = to_inf;
          so[4] = 1'b1;
          so[5] = 1'b1;
        end else if (v < 1024) begin
          zo = {s, 5'd0, v[9:0]};
          so[3] = 1'b1;
        end else begin
          e = msb(v) - 9;
          fr = (v >> (e - 1)) - 1024;
          zo = {s, e[4:0], fr[9:0]};
        end
      end
    end
  endtask

  logic [15:0] ra, rb, zw;
  logic [7:0]  sw;
  logic        rop;
  logic [2:0]  rrm;
  logic [15:0] spec_tbl [8];

  initial begin
    spec_tbl = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h7D01,
                 16'h0000, 16'h8000, 16'h7BFF, 16'hFBFF};
    rst_n = 1'b0;
    a = 16'h0;
    b = 16'h0;
    op = 1'b0;
    rnd = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset z", 32'(z), 32'h0);
    check("reset status", 32'(status), 32'h0);
    rst_n = 1'b1;

    run("one+one",   16'h3C00, 16'h3C00, 1'b0, 3'd0, 16'h4000, 8'h00);
    run("sub+sub",   16'h0001, 16'h0001, 1'b0, 3'd0, 16'h0002, 8'h08);
    run("minnorm-1", 16'h0400, 16'h0001, 1'b1, 3'd0, 16'h03FF, 8'h08);
    run("sub2norm",  16'h03FF, 16'h0001, 1'b0, 3'd0, 16'h0400, 8'h00);
    run("ovf ne",    16'h7BFF, 16'h7BFF, 1'b0, 3'd0, 16'h7C00, 8'h32);
    run("ovf tz",    16'h7BFF, 16'h7BFF, 1'b0, 3'd1, 16'h7BFF, 8'h30);
    run("ovf dn",    16'h7BFF, 16'h7BFF, 1'b0, 3'd3, 16'h7BFF, 8'h30);
    run("tie ne",    16'h3C00, 16'h1000, 1'b0, 3'd0, 16'h3C00, 8'h20);
    run("tie up",    16'h3C00, 16'h1000, 1'b0, 3'd2, 16'h3C01, 8'h20);
    run("tie na",    16'h3C00, 16'h1000, 1'b0, 3'd4, 16'h3C01, 8'h20);
    run("tie rm5",   16'h3C00, 16'h1000, 1'b0, 3'd5, 16'h3C00, 8'h20);
    run("cancel",    16'h3C00, 16'h3C00, 1'b1, 3'd0, 16'h0000, 8'h01);
    run("cancel dn", 16'h3C00, 16'h3C00, 1'b1, 3'd3, 16'h8000, 8'h01);
    run("negzeros",  16'h8000, 16'h0000, 1'b1, 3'd0, 16'h8000, 8'h01);
    run("inf-inf",   16'h7C00, 16'hFC00, 1'b0, 3'd0, 16'h7E00, 8'h04);
    run("nan",       16'h7E01, 16'h3C00, 1'b0, 3'd0, 16'h7E00, 8'h04);
    run("neg inf",   16'hFC00, 16'h3C00, 1'b0, 3'd0, 16'hFC00, 8'h02);

    a = 16'h3C00;
    b = 16'h3C00;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset z", 32'(z), 32'h0);
    check("midreset status", 32'(status), 32'h0);
    rst_n = 1'b1;
    run("after reset", 16'h3C00, 16'h3C00, 1'b0, 3'd0, 16'h4000, 8'h00);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 4))
        0: ;
        1: rb[14:10] = ra[14:10];
        2: rb = ra ^ 16'($urandom_range(0, 7)) ^ 16'h8000;
        3: begin
          ra[14:11] = 4'd0;
          rb[14:11] = 4'd0;
        end
        default: begin
          if ($urandom_range(0, 1) == 1) ra = spec_tbl[$urandom_range(0, 7)];
          else rb = spec_tbl[$urandom_range(0, 7)];
        end
      endcase
      rop = 1'($urandom_range(0, 1));
      rrm = 3'($urandom_range(0, 7));
      model(ra, rb, rop, rrm, zw, sw);
      apply(ra, rb, rop, rrm);
      check($sformatf("rand a=%h b=%h op=%0d rnd=%0d z", ra, rb, rop, rrm),
            32'(z), 32'(zw));
      check($sformatf("rand a=%h b=%h op=%0d rnd=%0d status", ra, rb, rop, rrm),
            32'(status), 32'(sw));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fp_addsub.md
# fp_addsub

Parameterised IEEE-754-style floating-point adder/subtractor. It computes z = a ± b with selectable rounding and an 8-bit exception status. Subnormals are fully supported. Default parameters give binary16 (half precision). It sits in the datapath as a one-cycle registered arithmetic unit.

## Interface
- P_EXP, 5: exponent field width.
- P_FRAC, 10: fraction field width (hidden bit excluded).
- P_BIAS, 15: exponent bias.
- P_WORD, 1+P_EXP+P_FRAC: derived word width; not overridden.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- a  in  P_WORD  operand A, {sign, exp, frac}.
- b  in  P_WORD  operand B.
- op  in  1  0 = add (a+b), 1 = subtract (a−b).
- rnd  in  3  rounding mode:
  - 0 = nearest-even
  - 1 = toward zero
  - 2 = toward +inf
  - 3 = toward −inf
  - 4 = nearest, ties away
  - 5–7 treated as 0
- z  out  P_WORD  result.
- status  out  8  exception flags (see Operation).

## Operation
- Effective operand: b' = b with sign XOR op.
- Special cases, decided before arithmetic:
  - Any NaN input (exp all-ones, frac ≠ 0) → canonical qNaN {0, all-ones, 1 followed by 0s}; invalid = 1.
  - +inf + −inf (effective) → canonical qNaN; invalid = 1.
  - One or both operands inf (same sign) → that inf; inf = 1.
- Finite path:
  - Unpack. Hidden bit = (exp ≠ 0). Subnormal effective exponent = 1.
  - Align the smaller magnitude by the exponent difference, keeping guard, round and sticky bits. Shift saturates at P_FRAC+3.
  - Add or subtract magnitudes according to the signs; the result takes the sign of the larger magnitude.
  - Normalise with a leading-zero count. Do not shift below exponent 1; the result becomes subnormal there.
  - Round per rnd. A mantissa carry-out increments the exponent.
- Overflow (rounded exponent ≥ all-ones):
  - Result is inf for nearest modes, and for directed modes whose direction is away from zero.
  - Otherwise result is max finite {sign, all-ones−1, all-ones}.
  - Sets huge and inexact.
- Exact zero result: sign +0, except rnd=3 gives −0. When both operands are zeros of the same effective sign, that sign is kept.
- status bits:
  - [0] zero: z is ±0.
  - [1] inf: z is ±inf.
  - [2] invalid.
  - [3] tiny: z nonzero and |z| < 2^(1−P_BIAS).
  - [4] huge: overflow.
  - [5] inexact: any discarded bit nonzero, or overflow.
  - [7:6] = 0.

## Timing
- Fully combinational core; z and status are registered.
- Latency 1 cycle: inputs present at rising edge N → z/status valid after edge N until edge N+1.
- New operation accepted every cycle; no handshake.
- rst_n low at an edge → z = 0, status = 0 after that edge. The first valid result follows the first edge with rst_n high.
- rnd and op are sampled at the same edge as a and b.

## Structure
- Package fp_addsub_pkg holds:
  - rounding-mode localparams (RND_NE, RND_TZ, RND_UP, RND_DN, RND_NA);
  - status bit indices (ST_ZERO, ST_INF, ST_INV, ST_TINY, ST_HUGE, ST_INEXACT).
- One sub-module, fp_addsub_lzc: parameterised leading-zero counter used for normalisation.
- Everything else is in fp_addsub.

## Test plan
All scenarios use default parameters and compare one cycle after applying inputs.
- 0x3C00 + 0x3C00, op=0, rnd=0 → z=0x4000, status=0x00.
- Subnormals: 0x0001 + 0x0001 → 0x0002, tiny. 0x0400 − 0x0001 (op=1) → 0x03FF, tiny, not inexact.
- Overflow: 0x7BFF + 0x7BFF, rnd=0 → 0x7C00, status inf|huge|inexact. Same with rnd=1 → 0x7BFF, huge|inexact.
- Tie rounding: 0x3C00 + 0x1000 (1 + 2^−11):
  - rnd=0 → 0x3C00, inexact;
  - rnd=2 → 0x3C01;
  - rnd=4 → 0x3C01.
- Cancellation: 0x3C00 − 0x3C00 → 0x0000, zero. With rnd=3 → 0x8000, zero.
- Specials: 0x7C00 + 0xFC00 → 0x7E00, invalid. 0x7E01 + 0x3C00 → 0x7E00, invalid. 0xFC00 + 0x3C00 → 0xFC00, inf.
- Reset: hold rst_n low for one edge mid-stream → z=0x0000, status=0x00. Random sweep of 1000 a/b/op/rnd vectors against a reference model.
